// File: rtl/p3_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : p3_fifo_reader
// Purpose  : Read-side consumer for the 17-bit p3 FIFO (RCLOCK domain).
//            Issues FIFO_RE, absorbs the one-cycle read latency in a
//            two-entry skid buffer and presents a valid/ready word stream.
//            FIFO bit DW marks end of frame. Supports flushing the rest of
//            a frame and counts frames delivered with M_LAST.
//            Optional build macro P3_FIFO_READER_LEN_CHECK_EN adds a
//            per-frame word limit (MAX_FRAME_WORDS) with truncation and a
//            sticky ERR_LEN flag.
// Revision : 1.0  initial release
// ============================================================================
module p3_fifo_reader #(
    parameter int DW              = 16,
    parameter int FCNT_W          = 16,
    parameter int MAX_FRAME_WORDS = 256
) (
    input  logic              RCLOCK,
    input  logic              RESET,
    input  logic [DW:0]       FIFO_Q,
    input  logic              FIFO_EMPTY,
    output logic              FIFO_RE,
    output logic [DW-1:0]     M_DATA,
    output logic              M_LAST,
    output logic              M_VALID,
    input  logic              M_READY,
    input  logic              FLUSH,
    output logic              BUSY_FLUSH,
    output logic [FCNT_W-1:0] FRAME_CNT,
    output logic              ERR_LEN
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_INFRAME = 2'd1;
    localparam logic [1:0] c_ST_FLUSH   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DW:0]       r_buf0;       // head entry
    logic [DW:0]       r_buf1;       // second entry
    logic [1:0]        r_occ;        // 0..2 buffered words
    logic              r_inflight;   // read issued last cycle, data on FIFO_Q now
    logic [FCNT_W-1:0] r_frame_cnt;
    logic              r_busy_flush;

    logic              w_pop;
    logic              w_force_last;
    logic              w_pop_last;
    logic              w_len_trunc;
    logic              w_flush_start;
    logic              w_disc_last;
    logic              w_push;
    logic [2:0]        w_used;
    logic [2:0]        w_limit;

    assign M_VALID = (r_occ != 2'd0);
    assign M_DATA  = r_buf0[DW-1:0];
    assign M_LAST  = r_buf0[DW] | w_force_last;

    assign w_pop      = M_VALID && M_READY;
    assign w_pop_last = w_pop && M_LAST;

    // A slot freed by this cycle's pop is usable by the read issued now, so
    // a steady stream with M_READY held high runs at one word per cycle.
    assign w_used  = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign FIFO_RE = !FIFO_EMPTY && !RESET && (w_used < w_limit);

    // A handshake in the flush cycle wins; if that word closed the frame the
    // flush request has nothing left to drop.
    assign w_flush_start = (r_state != c_ST_FLUSH) &&
                           ((FLUSH && !w_pop_last) || w_len_trunc);

    // Arriving words go to the buffer only outside flush handling.
    assign w_push = r_inflight && (r_state != c_ST_FLUSH) && !w_flush_start;

    // Detect an end-of-frame among everything discarded at flush entry.
    always_comb begin
        w_disc_last = r_inflight && FIFO_Q[DW];
        if (r_occ == 2'd2) begin
            w_disc_last = w_disc_last || r_buf1[DW];
        end
        if ((r_occ != 2'd0) && !w_pop) begin
            w_disc_last = w_disc_last || r_buf0[DW];
        end
    end

    // Next-state logic for frame tracking and flush handling.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_INFRAME: begin
                if (w_flush_start) begin
                    w_state_nxt = w_disc_last ? c_ST_IDLE : c_ST_FLUSH;
                end else if (w_pop) begin
                    w_state_nxt = w_pop_last ? c_ST_IDLE : c_ST_INFRAME;
                end
            end
            c_ST_FLUSH: begin
                if (r_inflight && FIFO_Q[DW]) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register and registered flush-busy flag.
    always_ff @(posedge RCLOCK or posedge RESET) begin
        if (RESET) begin
            r_state      <= c_ST_IDLE;
            r_busy_flush <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy_flush <= (w_state_nxt == c_ST_FLUSH);
        end
    end

    assign BUSY_FLUSH = r_busy_flush;

    // Outstanding-read tracker: data for a read issued now arrives next cycle.
    always_ff @(posedge RCLOCK or posedge RESET) begin
        if (RESET) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= FIFO_RE;
        end
    end

    // Two-entry in-order skid buffer; flush entry empties it in one edge.
    always_ff @(posedge RCLOCK or posedge RESET) begin
        if (RESET) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
            r_occ  <= 2'd0;
        end else if (w_flush_start) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= FIFO_Q;
                    end else begin
                        r_buf1 <= FIFO_Q;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= FIFO_Q;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= FIFO_Q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Count frames closed by a delivered M_LAST word; wraps naturally.
    always_ff @(posedge RCLOCK or posedge RESET) begin
        if (RESET) begin
            r_frame_cnt <= '0;
        end else if (w_pop_last) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign FRAME_CNT = r_frame_cnt;

`ifdef P3_FIFO_READER_LEN_CHECK_EN
    localparam int                  c_WCNT_W    = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(MAX_FRAME_WORDS - 1);

    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_err_len;

    // Head word is the frame's last permitted word: close the frame there.
    assign w_force_last = M_VALID && (r_wcnt == c_WCNT_LAST);
    assign w_len_trunc  = w_pop && w_force_last && !r_buf0[DW];

    // Words delivered in the current frame; cleared on frame end or flush.
    always_ff @(posedge RCLOCK or posedge RESET) begin
        if (RESET) begin
            r_wcnt <= '0;
        end else if ((r_state == c_ST_FLUSH) || w_flush_start || w_pop_last) begin
            r_wcnt <= '0;
        end else if (w_pop) begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // Sticky length-error flag, cleared only by reset.
    always_ff @(posedge RCLOCK or posedge RESET) begin
        if (RESET) begin
            r_err_len <= 1'b0;
        end else if (w_len_trunc) begin
            r_err_len <= 1'b1;
        end
    end

    assign ERR_LEN = r_err_len;
`else
    // No length limit in this build; the parameter stays in the interface so
    // both builds share one parameter list.
    assign w_force_last = 1'b0 & (MAX_FRAME_WORDS > 0);
    assign w_len_trunc  = 1'b0;
    assign ERR_LEN      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_p3_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_p3_fifo_reader
// Purpose  : Self-checking bench for p3_fifo_reader with a behavioural
//            one-cycle-latency FIFO and a scoreboard of expected words.
// Revision : 1.0  initial release
// ============================================================================
module tb_p3_fifo_reader;

    localparam int DW     = 16;
    localparam int FCNT_W = 4;
`ifdef P3_FIFO_READER_LEN_CHECK_EN
    localparam int MAXW = 4;
`else
    localparam int MAXW = 256;
`endif

    logic              RCLOCK     = 1'b0;
    logic              RESET      = 1'b1;
    logic [DW:0]       FIFO_Q     = '0;
    logic              FIFO_EMPTY = 1'b1;
    logic              FIFO_RE;
    logic [DW-1:0]     M_DATA;
    logic              M_LAST;
    logic              M_VALID;
    logic              M_READY    = 1'b0;
    logic              FLUSH      = 1'b0;
    logic              BUSY_FLUSH;
    logic [FCNT_W-1:0] FRAME_CNT;
    logic              ERR_LEN;

    p3_fifo_reader #(
        .DW              (DW),
        .FCNT_W          (FCNT_W),
        .MAX_FRAME_WORDS (MAXW)
    ) u_dut (
        .RCLOCK     (RCLOCK),
        .RESET      (RESET),
        .FIFO_Q     (FIFO_Q),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RE    (FIFO_RE),
        .M_DATA     (M_DATA),
        .M_LAST     (M_LAST),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .FLUSH      (FLUSH),
        .BUSY_FLUSH (BUSY_FLUSH),
        .FRAME_CNT  (FRAME_CNT),
        .ERR_LEN    (ERR_LEN)
    );

    always #5 RCLOCK = ~RCLOCK;

    int          total      = 0;
    int          bad        = 0;
    int          exp_frames = 0;
    int          base       = 0;
    logic [DW:0] fifo[$];
    logic [DW:0] sb[$];
    logic        toggle_mode = 1'b0;
    logic        gate        = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total = total + 1;
        if (obs !== exp_v) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // FIFO model: read data one cycle after RE, empty flag updated at the edge.
    always @(posedge RCLOCK) begin
        logic g;
        if (FIFO_RE && (fifo.size() > 0)) begin
            FIFO_Q <= fifo.pop_front();
        end
        g = toggle_mode ? ~gate : 1'b0;
        gate <= g;
        FIFO_EMPTY <= (fifo.size() == 0) || g;
    end

    // Output monitor: compare presented words against the scoreboard head.
    always @(negedge RCLOCK) begin
        if (!RESET) begin
            if (FIFO_EMPTY) begin
                check("re_while_empty", 32'(FIFO_RE), 32'd0);
            end
            if (M_VALID) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(M_VALID), 32'd0);
                end else begin
                    check("m_data", 32'(M_DATA), 32'(sb[0][DW-1:0]));
                    check("m_last", 32'(M_LAST), 32'(sb[0][DW]));
                    if (M_READY) begin
                        if (sb[0][DW]) begin
                            exp_frames = exp_frames + 1;
                        end
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge RCLOCK);
        #1;
    endtask

    task automatic put(input logic [DW:0] w, input bit keep);
        fifo.push_back(w);
        if (keep) begin
            sb.push_back(w);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || fifo.size() != 0 || M_VALID) && n < 200) begin
            tick();
            n = n + 1;
        end
        check(tag, 32'(n < 200), 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_fifo_re"},   32'(FIFO_RE),    32'd0);
        check({pfx, "_m_valid"},   32'(M_VALID),    32'd0);
        check({pfx, "_m_data"},    32'(M_DATA),     32'd0);
        check({pfx, "_m_last"},    32'(M_LAST),     32'd0);
        check({pfx, "_busy"},      32'(BUSY_FLUSH), 32'd0);
        check({pfx, "_frame_cnt"}, 32'(FRAME_CNT),  32'd0);
        check({pfx, "_err_len"},   32'(ERR_LEN),    32'd0);
    endtask

    function automatic logic [31:0] exp_cnt();
        return 32'((exp_frames - base) % (1 << FCNT_W));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          re_cyc;
        int          v_cyc[$];
        int          re_n;
        int          n;
        logic [DW:0] w;

        // Reset state
        repeat (3) tick();
        check_zero("rst");
        RESET = 1'b0;
        tick();

        // Basic three-word frame, latency and throughput
        put(17'h00001, 1'b1);
        put(17'h00002, 1'b1);
        put(17'h10003, 1'b1);
        M_READY = 1'b1;
        re_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (FIFO_RE && re_cyc < 0) re_cyc = i;
            if (M_VALID) v_cyc.push_back(i);
        end
        check("t1_valid_count", 32'(v_cyc.size()), 32'd3);
        if (v_cyc.size() >= 3) begin
            check("t1_latency", 32'(v_cyc[0] - re_cyc), 32'd2);
            check("t1_back_to_back", 32'(v_cyc[2] - v_cyc[0]), 32'd2);
        end
        drain("t1_drain");
        check("t1_frame_cnt", 32'(FRAME_CNT), exp_cnt());

        // Backpressure: only two reads may be issued while stalled
        M_READY = 1'b0;
        put(17'h00031, 1'b1);
        put(17'h00032, 1'b1);
        put(17'h10033, 1'b1);
        put(17'h00034, 1'b1);
        put(17'h10035, 1'b1);
        re_n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (FIFO_RE) re_n = re_n + 1;
        end
        check("t2_re_pulses", 32'(re_n), 32'd2);
        check("t2_valid", 32'(M_VALID), 32'd1);
        check("t2_head", 32'(M_DATA), 32'h0031);
        M_READY = 1'b1;
        drain("t2_drain");
        check("t2_frame_cnt", 32'(FRAME_CNT), exp_cnt());

        // Toggling empty flag with random backpressure
        toggle_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = {1'b0, 16'(16'h0040 + i)};
            w[DW] = ((i % 4) == 3);
            put(w, 1'b1);
        end
        n = 0;
        while ((sb.size() != 0 || fifo.size() != 0) && n < 300) begin
            M_READY = 1'($urandom_range(0, 1));
            tick();
            n = n + 1;
        end
        check("t3_done", 32'(n < 300), 32'd1);
        M_READY = 1'b1;
        toggle_mode = 1'b0;
        drain("t3_drain");
        check("t3_frame_cnt", 32'(FRAME_CNT), exp_cnt());

        // Flush after two accepted words of a six-word frame
        for (int i = 1; i <= 5; i++) begin
            put({1'b0, 16'(16'h0010 + i)}, (i <= 2));
        end
        put(17'h1AAAA, 1'b0);
        n = 0;
        re_n = 0;
        while (n < 2 && re_n < 30) begin
            tick();
            re_n = re_n + 1;
            if (M_VALID) begin
                n = n + 1;
                if (n == 2) FLUSH = 1'b1;
            end
        end
        check("t4_flush_pulse", 32'(n), 32'd2);
        tick();
        FLUSH = 1'b0;
        check("t4_busy", 32'(BUSY_FLUSH), 32'd1);
        check("t4_valid_low", 32'(M_VALID), 32'd0);
        n = 0;
        while (BUSY_FLUSH && n < 50) begin
            tick();
            n = n + 1;
        end
        check("t4_flush_exit", 32'(n < 50), 32'd1);
        drain("t4_drain");
        check("t4_cnt_after_flush", 32'(FRAME_CNT), exp_cnt());
        put(17'h10055, 1'b1);
        drain("t4_next_drain");
        check("t4_frame_cnt", 32'(FRAME_CNT), exp_cnt());

        // Asynchronous reset, then counter wrap
        #3;
        RESET = 1'b1;
        #1;
        check_zero("arst");
        base = exp_frames;
        fifo.delete();
        sb.delete();
        tick();
        tick();
        RESET = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            put({1'b1, 16'(16'h0100 + i)}, 1'b1);
        end
        drain("t5_drain");
        check("t5_wrap_cnt", 32'(FRAME_CNT), exp_cnt());
        check("t5_wrap_one", exp_cnt(), 32'd1);

        // Seven-word frame: truncated with the length check, intact without
        for (int i = 1; i <= 6; i++) begin
            w = {1'b0, 16'(16'h0020 + i)};
            fifo.push_back(w);
`ifdef P3_FIFO_READER_LEN_CHECK_EN
            if (i < 4) sb.push_back(w);
            if (i == 4) sb.push_back({1'b1, w[DW-1:0]});
`else
            sb.push_back(w);
`endif
        end
`ifdef P3_FIFO_READER_LEN_CHECK_EN
        fifo.push_back(17'h10027);
`else
        put(17'h10027, 1'b1);
`endif
        drain("t6_drain");
`ifdef P3_FIFO_READER_LEN_CHECK_EN
        check("t6_err_len", 32'(ERR_LEN), 32'd1);
`else
        check("t6_err_len", 32'(ERR_LEN), 32'd0);
`endif
        check("t6_frame_cnt", 32'(FRAME_CNT), exp_cnt());
        put(17'h10056, 1'b1);
        drain("t6_next_drain");
        check("t6_next_cnt", 32'(FRAME_CNT), exp_cnt());
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
